mem_arbiter: RTL

Shares the single external memory port between the CPU core and a host/loader requester (e.g. a program-upload or debug port). The core has no stall input, so the arbiter drives a clock-enable pulse `cpuStep`. The core advances one cycle only when its pending memory access has completed. The arbiter sits between the CPU top level and the external memory interface, and enforces bounded host bursts so the CPU cannot starve.

---
 rtl/mem_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - CPU/host arbiter for a single external memory port
module mem_arbiter #(
  parameter int ADDR_WIDTH     = 15,
  parameter int DATA_WIDTH     = 8,
  parameter int HOST_MAX_BURST = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpuRun,
  input  logic [ADDR_WIDTH-1:0] cpuAddr,
  input  logic                  cpuWriteReq,
  input  logic [DATA_WIDTH-1:0] cpuWriteData,
  output logic [DATA_WIDTH-1:0] cpuReadData,
  output logic                  cpuStep,
  input  logic                  hostReq,
  input  logic [ADDR_WIDTH-1:0] hostAddr,
  input  logic                  hostWe,
  input  logic [DATA_WIDTH-1:0] hostWData,
  output logic                  hostGnt,
  output logic [DATA_WIDTH-1:0] hostRData,
  output logic                  hostDone,
  output logic                  memReq,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic                  memWe,
  output logic [DATA_WIDTH-1:0] memWData,
  input  logic [DATA_WIDTH-1:0] memRData,
  input  logic                  memReady
);

  localparam int CNT_W = $clog2(HOST_MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(HOST_MAX_BURST);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_ACC  = 2'd1,
    HOST_ACC = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  host_gnt_q, host_gnt_d;
  logic                  cpu_step_q, cpu_step_d;
  logic                  host_done_q, host_done_d;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_WIDTH-1:0] host_rdata_q, host_rdata_d;
  logic [CNT_W-1:0]      host_count_q, host_count_d;
  logic                  host_wins;

  // The host takes the port unless it has used its burst allowance while the CPU runs
  assign host_wins = hostReq && ((host_count_q < BURST_MAX) || !cpuRun);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: choose a requester from IDLE, go back to IDLE once memory completes
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (host_wins) begin
          state_d = HOST_ACC;
        end else if (cpuRun) begin
          state_d = CPU_ACC;
        end
      end
      CPU_ACC, HOST_ACC: begin
        if (memReady) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: latch the winner's request, then release the port and pulse done on memReady
  always_comb begin
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = mem_we_q;
    mem_wdata_d  = mem_wdata_q;
    host_gnt_d   = host_gnt_q;
    cpu_step_d   = 1'b0;
    host_done_d  = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    host_rdata_d = host_rdata_q;
    host_count_d = host_count_q;
    case (state_q)
      IDLE: begin
        if (host_wins) begin
          mem_req_d   = 1'b1;
          mem_addr_d  = hostAddr;
          mem_we_d    = hostWe;
          mem_wdata_d = hostWData;
          host_gnt_d  = 1'b1;
        end else if (cpuRun) begin
          mem_req_d   = 1'b1;
          mem_addr_d  = cpuAddr;
          mem_we_d    = cpuWriteReq;
          mem_wdata_d = cpuWriteData;
        end
      end
      CPU_ACC: begin
        if (memReady) begin
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          host_gnt_d   = 1'b0;
          cpu_step_d   = 1'b1;
          host_count_d = '0;
          if (!mem_we_q) begin
            cpu_rdata_d = memRData;
          end
        end
      end
      HOST_ACC: begin
        if (memReady) begin
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          host_gnt_d  = 1'b0;
          host_done_d = 1'b1;
          if (host_count_q != BURST_MAX) begin
            host_count_d = host_count_q + 1'b1;
          end
          if (!mem_we_q) begin
            host_rdata_d = memRData;
          end
        end
      end
      default: ;
    endcase
    // A stopped CPU cannot be starved, so the host burst limit is lifted
    if (!cpuRun) begin
      host_count_d = '0;
    end
  end

  // Registered outputs and burst counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      host_gnt_q   <= 1'b0;
      cpu_step_q   <= 1'b0;
      host_done_q  <= 1'b0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
      host_count_q <= '0;
    end else begin
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      host_gnt_q   <= host_gnt_d;
      cpu_step_q   <= cpu_step_d;
      host_done_q  <= host_done_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
      host_count_q <= host_count_d;
    end
  end

  assign memReq      = mem_req_q;
  assign memAddr     = mem_addr_q;
  assign memWe       = mem_we_q;
  assign memWData    = mem_wdata_q;
  assign hostGnt     = host_gnt_q;
  assign cpuStep     = cpu_step_q;
  assign hostDone    = host_done_q;
  assign cpuReadData = cpu_rdata_q;
  assign hostRData   = host_rdata_q;

endmodule
